// File: rtl/dsp_pkg.sv
// Shared constants and types for the XINTF DPBRAM port-A arbiter.
// Requester ids, DPBRAM widths and the arbiter FSM state encoding.
package dsp_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_XINTF = 2'd0;
  localparam logic [1:0] REQ_WF    = 2'd1;
  localparam logic [1:0] REQ_PS    = 2'd2;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_OWN0 = 2'd1;
  localparam arb_state_t ST_OWN1 = 2'd2;
  localparam arb_state_t ST_OWN2 = 2'd3;

  function automatic logic [NUM_REQ-1:0] state_to_gnt(input arb_state_t st);
    logic [NUM_REQ-1:0] g;
    g = '0;
    case (st)
      ST_OWN0: g = 3'b001;
      ST_OWN1: g = 3'b010;
      ST_OWN2: g = 3'b100;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/xintf_ram_arbiter_rr_pick2.sv
// Combinational round-robin choice between requesters 1 (WF copy) and 2 (PS test).
// ptr_i names the requester that wins when both are asking.
module rr_pick2
  import dsp_pkg::*;
(
  input  logic [1:0] ptr_i,
  input  logic [1:0] req_i,   // bit 0 = requester 1, bit 1 = requester 2
  output logic       valid_o,
  output logic [1:0] id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = REQ_WF;
    if (ptr_i == REQ_PS) begin
      id_o = req_i[1] ? REQ_PS : REQ_WF;
    end else begin
      id_o = req_i[0] ? REQ_WF : REQ_PS;
    end
  end

endmodule

// File: rtl/xintf_ram_arbiter.sv
// Arbitrates DPBRAM port A between XINTF FSM (fixed priority), WF copy and PS test.
// Optional per-requester beat counters are built when XINTF_ARB_STATS_EN is defined.
module xintf_ram_arbiter
  import dsp_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  output logic [NUM_REQ-1:0]   o_gnt,
  input  logic [ADDR_W-1:0]    i_addr0,
  input  logic [ADDR_W-1:0]    i_addr1,
  input  logic [ADDR_W-1:0]    i_addr2,
  input  logic [NUM_REQ-1:0]   i_we,
  input  logic [DATA_W-1:0]    i_din0,
  input  logic [DATA_W-1:0]    i_din1,
  input  logic [DATA_W-1:0]    i_din2,
  output logic [DATA_W-1:0]    o_rdata,
  output logic [NUM_REQ-1:0]   o_rvalid,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic                 o_ram_ce,
  output logic                 o_ram_we,
  output logic [DATA_W-1:0]    o_ram_din,
`ifdef XINTF_ARB_STATS_EN
  input  logic                 i_stat_clr,
  output logic [31:0]          o_beat_cnt0,
  output logic [31:0]          o_beat_cnt1,
  output logic [31:0]          o_beat_cnt2,
`endif
  input  logic [DATA_W-1:0]    i_ram_dout
);

  localparam logic [5:0] BURST_LIM = 6'(MAX_BURST);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [1:0]          ptr_q, ptr_d, ptr_eff;
  logic [4:0]          burst_q, burst_d;
  logic [5:0]          burst_inc;

  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_ce_q, ram_we_q;
  logic [DATA_W-1:0]   ram_din_q;

  logic [NUM_REQ-1:0]  beat_vec, rd_beat_vec;
  logic                beat, low_owner, burst_hit, rearb;
  logic                pick_valid;
  logic [1:0]          pick_id;

  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_din;

  logic [NUM_REQ-1:0]  rd_pipe_q [RD_LAT+1];

  assign beat_vec    = i_req & gnt_q;
  assign beat        = |beat_vec;
  assign rd_beat_vec = beat_vec & ~i_we;
  assign low_owner   = (state_q == ST_OWN1) || (state_q == ST_OWN2);
  assign burst_inc   = {1'b0, burst_q} + 6'd1;
  assign burst_hit   = low_owner && beat && (burst_inc == BURST_LIM);
  // A missing owner request also covers the IDLE state, where no beat is possible.
  assign rearb       = !beat || burst_hit || (low_owner && i_req[0]);

  // Ending a 1/2 ownership moves the pointer past that owner before picking.
  assign ptr_eff = (state_q == ST_OWN1) ? REQ_PS :
                   (state_q == ST_OWN2) ? REQ_WF : ptr_q;

  rr_pick2 u_pick (
    .ptr_i   (ptr_eff),
    .req_i   (i_req[2:1]),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q + {4'd0, beat};
    if (rearb) begin
      ptr_d   = ptr_eff;
      burst_d = '0;
      if (i_req[0]) begin
        state_d = ST_OWN0;
      end else if (pick_valid) begin
        state_d = (pick_id == REQ_PS) ? ST_OWN2 : ST_OWN1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    sel_addr = i_addr0;
    sel_we   = i_we[0];
    sel_din  = i_din0;
    if (gnt_q[1]) begin
      sel_addr = i_addr1;
      sel_we   = i_we[1];
      sel_din  = i_din1;
    end else if (gnt_q[2]) begin
      sel_addr = i_addr2;
      sel_we   = i_we[2];
      sel_din  = i_din2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= REQ_WF;
      burst_q    <= '0;
      ram_addr_q <= '0;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= state_to_gnt(state_d);
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      ram_ce_q <= beat;
      ram_we_q <= beat && sel_we;
      if (beat) begin
        ram_addr_q <= sel_addr;
        ram_din_q  <= sel_din;
      end
    end
  end

  // One-hot read tags; stage RD_LAT lines up with i_ram_dout for that beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k <= RD_LAT; k++) rd_pipe_q[k] <= '0;
    end else begin
      rd_pipe_q[0] <= rd_beat_vec;
      for (int k = 1; k <= RD_LAT; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
    end
  end

  assign o_gnt      = gnt_q;
  assign o_rvalid   = rd_pipe_q[RD_LAT];
  assign o_rdata    = (|rd_pipe_q[RD_LAT]) ? i_ram_dout : '0;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_ce   = ram_ce_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_din  = ram_din_q;

`ifdef XINTF_ARB_STATS_EN
  logic [31:0] beat_cnt_q [NUM_REQ];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_stat_clr) begin
      for (int n = 0; n < NUM_REQ; n++) beat_cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (beat_vec[n]) beat_cnt_q[n] <= beat_cnt_q[n] + 32'd1;
      end
    end
  end

  assign o_beat_cnt0 = beat_cnt_q[0];
  assign o_beat_cnt1 = beat_cnt_q[1];
  assign o_beat_cnt2 = beat_cnt_q[2];
`endif

endmodule

// File: tb/tb_xintf_ram_arbiter.sv
// Bench for xintf_ram_arbiter: directed scenarios plus random traffic against a
// rule-level reference model and a small DPBRAM model.
module tb_xintf_ram_arbiter;

  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [2:0]  i_req;
  logic [2:0]  o_gnt;
  logic [8:0]  i_addr0, i_addr1, i_addr2;
  logic [2:0]  i_we;
  logic [15:0] i_din0, i_din1, i_din2;
  logic [15:0] o_rdata;
  logic [2:0]  o_rvalid;
  logic [8:0]  o_ram_addr;
  logic        o_ram_ce, o_ram_we;
  logic [15:0] o_ram_din;
  logic [15:0] i_ram_dout;
`ifdef XINTF_ARB_STATS_EN
  logic        i_stat_clr;
  logic [31:0] o_beat_cnt0, o_beat_cnt1, o_beat_cnt2;
`endif

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  xintf_ram_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .o_gnt      (o_gnt),
    .i_addr0    (i_addr0),
    .i_addr1    (i_addr1),
    .i_addr2    (i_addr2),
    .i_we       (i_we),
    .i_din0     (i_din0),
    .i_din1     (i_din1),
    .i_din2     (i_din2),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .o_ram_addr (o_ram_addr),
    .o_ram_ce   (o_ram_ce),
    .o_ram_we   (o_ram_we),
    .o_ram_din  (o_ram_din),
`ifdef XINTF_ARB_STATS_EN
    .i_stat_clr (i_stat_clr),
    .o_beat_cnt0(o_beat_cnt0),
    .o_beat_cnt1(o_beat_cnt1),
    .o_beat_cnt2(o_beat_cnt2),
`endif
    .i_ram_dout (i_ram_dout)
  );

  function automatic logic [15:0] init_word(input int a);
    return (a == 5) ? 16'h5A5A : 16'((a * 16'h0101) ^ 16'h3C5A);
  endfunction

  // ---------------- DPBRAM model (latency 1) ----------------
  logic [15:0] ram_mem [512];
  bit          ram_init_done = 1'b0;
  initial i_ram_dout = 16'h0;
  always @(posedge i_clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 512; i++) ram_mem[i] = init_word(i);
      ram_init_done = 1'b1;
    end
    if (o_ram_ce && o_ram_we) ram_mem[o_ram_addr] = o_ram_din;
    if (o_ram_ce && !o_ram_we) i_ram_dout <= ram_mem[o_ram_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  int          m_owner, m_cnt, m_ptr;
  logic [8:0]  e_addr;
  logic        e_ce, e_we;
  logic [15:0] e_din;
  logic [15:0] mem_ref [512];
  logic [15:0] exp_q[$];
  int          exp_id_q[$];
  int          exp_due_q[$];
  int          cyc;
  int          n_cmp, n_err;

  function automatic logic [2:0] onehot(input int id);
    return (id < 0) ? 3'b000 : 3'(1 << id);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 1;
    e_addr = '0; e_ce = 1'b0; e_we = 1'b0; e_din = '0;
    exp_q.delete(); exp_id_q.delete(); exp_due_q.delete();
  endtask

  // One clock: check DUT against the model at negedge, advance model, return #1 after posedge.
  task automatic step();
    logic [2:0]  ev;
    logic [15:0] ed, d;
    logic [8:0]  a;
    logic        w;
    bit          beat, rearb;
    int          nxt;
    @(negedge i_clk);
    chk("gnt", o_gnt, onehot(m_owner));
    chk("ram_ce", o_ram_ce, e_ce);
    chk("ram_we", o_ram_we, e_we);
    chk("ram_addr", o_ram_addr, e_addr);
    chk("ram_din", o_ram_din, e_din);
    ev = 3'b000; ed = 16'h0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      ev = onehot(exp_id_q[0]); ed = exp_q[0];
      void'(exp_due_q.pop_front()); void'(exp_id_q.pop_front()); void'(exp_q.pop_front());
    end
    chk("rvalid", o_rvalid, ev);
    chk("rdata", o_rdata, ed);

    if (i_rst) begin
      model_reset();
    end else begin
      beat = (m_owner >= 0) && i_req[m_owner];
      if (beat) begin
        a = (m_owner == 0) ? i_addr0 : (m_owner == 1) ? i_addr1 : i_addr2;
        d = (m_owner == 0) ? i_din0  : (m_owner == 1) ? i_din1  : i_din2;
        w = i_we[m_owner];
        e_ce = 1'b1; e_we = w; e_addr = a; e_din = d;
        if (w) mem_ref[a] = d;
        else begin
          exp_due_q.push_back(cyc + 1 + RD_LAT);
          exp_id_q.push_back(m_owner);
          exp_q.push_back(mem_ref[a]);
        end
      end else begin
        e_ce = 1'b0; e_we = 1'b0;
      end
      rearb = !beat || (m_owner > 0 && (m_cnt + 1 == MAX_BURST || i_req[0]));
      if (rearb) begin
        if (m_owner > 0) m_ptr = 3 - m_owner;
        m_cnt = 0;
        if (i_req[0]) nxt = 0;
        else if (i_req[m_ptr]) nxt = m_ptr;
        else if (i_req[3 - m_ptr]) nxt = 3 - m_ptr;
        else nxt = -1;
        m_owner = nxt;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fields();
    i_addr0 = 9'($urandom_range(0, 15));
    i_addr1 = 9'($urandom_range(0, 15));
    i_addr2 = 9'($urandom_range(0, 15));
    i_we    = 3'($urandom_range(0, 7));
    i_din0  = 16'($urandom);
    i_din1  = 16'($urandom);
    i_din2  = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    i_req = 3'b000;
    for (int i = 0; i < n; i++) begin
      drive_fields();
      step();
    end
  endtask

  logic [2:0] g_hist [48];
  int         cnt0, pulses;
  logic [2:0] r;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 512; i++) mem_ref[i] = init_word(i);
    i_rst = 1'b1; i_req = 3'b000; drive_fields();
`ifdef XINTF_ARB_STATS_EN
    i_stat_clr = 1'b0;
`endif
    @(posedge i_clk); #1;
    model_reset();
    step();
    i_rst = 1'b0;
    chk("reset_gnt", o_gnt, 3'b000);
    chk("reset_rvalid", o_rvalid, 3'b000);
    chk("reset_ram_ce", o_ram_ce, 1'b0);
    step();

    // Single read by requester 2 of preloaded address 5.
    i_req = 3'b100; i_addr2 = 9'h005; i_we = 3'b000;
    step();
    chk("single_gnt", o_gnt, 3'b100);
    step();
    chk("single_ram_addr", o_ram_addr, 9'h005);
    i_req = 3'b000;
    step();
    chk("single_rvalid", o_rvalid, 3'b100);
    chk("single_rdata", o_rdata, 16'h5A5A);

    // Round-robin between 1 and 2 under the burst limit.
    i_req = 3'b110; drive_fields();
    step();
    for (int i = 0; i < 48; i++) begin
      g_hist[i] = o_gnt;
      drive_fields();
      step();
    end
    chk("rr_first", g_hist[0], 3'b010);
    chk("rr_end1", g_hist[15], 3'b010);
    chk("rr_start2", g_hist[16], 3'b100);
    chk("rr_end2", g_hist[31], 3'b100);
    chk("rr_back1", g_hist[32], 3'b010);
    idle_cycles(3);

    // Preemption of requester 1 on its 5th beat.
    i_req = 3'b010; drive_fields();
    step();
    for (int i = 0; i < 4; i++) begin drive_fields(); step(); end
    i_req = 3'b011; drive_fields();
    step();
    chk("preempt_gnt", o_gnt, 3'b001);
    chk("preempt_beat5", o_ram_ce, 1'b1);
    cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_gnt == 3'b001) cnt0++;
      drive_fields();
      step();
    end
    chk("preempt_hold40", cnt0, 40);
    i_req = 3'b010; drive_fields();
    step();
    chk("preempt_regain", o_gnt, 3'b010);
    idle_cycles(3);

    // Requester 0 writes 0x1234 to 0x1FF then reads it back.
    i_req = 3'b001; i_we = 3'b001; i_addr0 = 9'h1FF; i_din0 = 16'h1234;
    step();
    step();
    i_we = 3'b000;
    step();
    i_req = 3'b000;
    step();
    chk("b2b_rvalid", o_rvalid, 3'b001);
    chk("b2b_rdata", o_rdata, 16'h1234);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (|o_rvalid) pulses++;
    end
    chk("b2b_single_pulse", pulses, 0);

    // Reset one cycle after a read beat.
    i_req = 3'b100; i_we = 3'b000; i_addr2 = 9'h00A;
    step();
    step();
    i_rst = 1'b1; i_req = 3'b000;
    step();
    i_rst = 1'b0;
    chk("rst_gnt", o_gnt, 3'b000);
    chk("rst_rvalid", o_rvalid, 3'b000);
    chk("rst_rdata", o_rdata, 16'h0);
    chk("rst_ram_addr", o_ram_addr, 9'h0);
    chk("rst_ram_ce_we", {o_ram_ce, o_ram_we}, 2'b00);
    chk("rst_ram_din", o_ram_din, 16'h0);
    idle_cycles(2);

    // Random traffic with sticky requests and occasional reset.
    r = 3'b000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      i_req = r;
      i_rst = ($urandom_range(0, 199) == 0);
      drive_fields();
      step();
    end
    i_rst = 1'b0;
    idle_cycles(4);

`ifdef XINTF_ARB_STATS_EN
    i_rst = 1'b1; step(); i_rst = 1'b0;
    i_req = 3'b001; drive_fields();
    step();
    for (int i = 0; i < 10; i++) begin drive_fields(); step(); end
    i_req = 3'b100;
    step();
    for (int i = 0; i < 3; i++) begin drive_fields(); step(); end
    i_req = 3'b000;
    step();
    chk("stat_cnt0", o_beat_cnt0, 32'd10);
    chk("stat_cnt1", o_beat_cnt1, 32'd0);
    chk("stat_cnt2", o_beat_cnt2, 32'd3);
    i_stat_clr = 1'b1;
    step();
    i_stat_clr = 1'b0;
    chk("stat_clr", o_beat_cnt0 | o_beat_cnt1 | o_beat_cnt2, 32'd0);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
